axis_pl_to_ps_core: RTL and testbench

- Single-clock AXI-Stream width down-converter between PL sample logic (128-bit beats) and the PS capture path (32-bit beats).
- Input beats enter an internal synchronous FIFO, the same function as the codebase's axis_sync_fifo, instantiated or inlined.
- A serializer splits each FIFO beat into IN_WIDTH/OUT_WIDTH output words, least-significant word first.

---
 rtl/axis_pl_to_ps_core.sv | 101 ++++++++++
 tb/tb_axis_pl_to_ps_core.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/axis_pl_to_ps_core.sv
// AXI-Stream width down-converter: a FIFO of IN_WIDTH beats feeds an LSW-first serializer.
// Define AXIS_PL_TO_PS_TLAST_EN to add m_axis_tlast, which marks every PKT_WORDS-th output word.
module axis_pl_to_ps_core #(
   parameter int IN_WIDTH        = 128,
   parameter int OUT_WIDTH       = 32,
   parameter int FIFO_DEPTH_LOG2 = 4,
   parameter int PKT_WORDS       = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [IN_WIDTH-1:0]        s_axis_tdata,
   input  logic                       s_axis_tvalid,
   output logic                       s_axis_tready,
   output logic [OUT_WIDTH-1:0]       m_axis_tdata,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output logic [FIFO_DEPTH_LOG2:0]   fifo_level
`ifdef AXIS_PL_TO_PS_TLAST_EN
   ,
   output logic                       m_axis_tlast
`endif
);

   localparam int R     = IN_WIDTH / OUT_WIDTH;
   localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam int AW    = FIFO_DEPTH_LOG2;
   localparam int KW    = (R > 1) ? $clog2(R) : 1;

   logic [IN_WIDTH-1:0] mem [DEPTH];
   logic [AW:0]         wr_ptr, rd_ptr;
   logic                fifo_full, fifo_empty;
   logic                wr_en, rd_en;

   logic [IN_WIDTH-1:0] ser_beat;
   logic                ser_vld;
   logic [KW-1:0]       k;
   logic                out_hs, last_hs;

   assign fifo_empty    = (wr_ptr == rd_ptr);
   assign fifo_full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign fifo_level    = wr_ptr - rd_ptr;
   assign s_axis_tready = !fifo_full;

   // Full refuses writes even when the serializer pops on the same edge.
   assign wr_en   = s_axis_tvalid && !fifo_full;
   assign out_hs  = ser_vld && m_axis_tready;
   assign last_hs = out_hs && (k == KW'(R - 1));
   assign rd_en   = !fifo_empty && (!ser_vld || last_hs);

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= s_axis_tdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Reload on the last-word edge keeps the output stream gapless.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ser_beat <= '0;
         ser_vld  <= 1'b0;
         k        <= '0;
      end else begin
         if (rd_en) begin
            ser_beat <= mem[rd_ptr[AW-1:0]];
            ser_vld  <= 1'b1;
            k        <= '0;
         end else if (last_hs) begin
            ser_vld  <= 1'b0;
            k        <= '0;
         end else if (out_hs) begin
            k        <= k + 1'b1;
         end
      end
   end

   assign m_axis_tvalid = ser_vld;
   assign m_axis_tdata  = ser_beat[int'(k)*OUT_WIDTH +: OUT_WIDTH];

`ifdef AXIS_PL_TO_PS_TLAST_EN
   localparam int CW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
   logic [CW-1:0] pkt_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pkt_cnt <= '0;
      else if (out_hs)
         pkt_cnt <= (pkt_cnt == CW'(PKT_WORDS - 1)) ? '0 : pkt_cnt + 1'b1;
   end

   assign m_axis_tlast = ser_vld && (pkt_cnt == CW'(PKT_WORDS - 1));
`endif

endmodule

// File: tb/tb_axis_pl_to_ps_core.sv
// Directed bench for axis_pl_to_ps_core: reset, ordering, full/backpressure, stall, mid-stream reset.
module tb_axis_pl_to_ps_core;

   localparam int IW = 128;
   localparam int OW = 32;
   localparam int LG = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [IW-1:0]   s_axis_tdata = '0;
   logic            s_axis_tvalid = 1'b0;
   logic            s_axis_tready;
   logic [OW-1:0]   m_axis_tdata;
   logic            m_axis_tvalid;
   logic            m_axis_tready = 1'b0;
   logic [LG:0]     fifo_level;
`ifdef AXIS_PL_TO_PS_TLAST_EN
   logic            m_axis_tlast;
`endif

   axis_pl_to_ps_core #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .FIFO_DEPTH_LOG2(LG), .PKT_WORDS(16)) dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .fifo_level(fifo_level)
`ifdef AXIS_PL_TO_PS_TLAST_EN
      , .m_axis_tlast(m_axis_tlast)
`endif
   );

   always #5 clk = ~clk;

   int errs = 0;
   int checks = 0;
   int hs_cnt = 0;
   logic [31:0] expq[$];

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [IW-1:0] mk(input int i);
      logic [IW-1:0] b;
      for (int j = 0; j < 4; j++) b[j*32 +: 32] = 32'hB000_0000 | (32'(i) << 4) | 32'(j);
      return b;
   endfunction

   task automatic push_beat(input logic [IW-1:0] b);
      for (int j = 0; j < 4; j++) expq.push_back(b[j*32 +: 32]);
   endtask

   // Called at a negedge where tvalid && tready: the coming edge consumes this word.
   task automatic take_word();
      logic [31:0] e;
      chk("word_expected", 128'(expq.size() > 0), 128'(1));
      if (expq.size() > 0) begin
         e = expq.pop_front();
         chk("word_data", 128'(m_axis_tdata), 128'(e));
      end
`ifdef AXIS_PL_TO_PS_TLAST_EN
      chk("tlast", 128'(m_axis_tlast), 128'((hs_cnt % 16) == 15));
`endif
      hs_cnt++;
   endtask

   initial begin
      int acc, n_in;
      logic prev_stall;
      logic [31:0] prev_data;

      // Reset
      repeat (10) @(negedge clk);
      chk("rst_tvalid", 128'(m_axis_tvalid), 128'(0));
      chk("rst_tdata", 128'(m_axis_tdata), 128'(0));
      chk("rst_level", 128'(fifo_level), 128'(0));
      rst = 1'b0;
      @(negedge clk);
      chk("rel_tready", 128'(s_axis_tready), 128'(1));
      chk("rel_tvalid", 128'(m_axis_tvalid), 128'(0));
      chk("rel_level", 128'(fifo_level), 128'(0));

      // Ordering with the output stalled
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 128'h00001111222233334444555566667777;
      @(negedge clk);
      chk("ord_rdy", 128'(s_axis_tready), 128'(1));
      s_axis_tdata  = 128'h88889999AAAABBBBCCCCDDDDEEEEFFFF;
      @(negedge clk);
      s_axis_tvalid = 1'b0;
      repeat (100) @(negedge clk);
      chk("ord_level", 128'(fifo_level), 128'(1));
      chk("ord_tvalid", 128'(m_axis_tvalid), 128'(1));
      chk("ord_tdata", 128'(m_axis_tdata), 128'h66667777);

      // Drain: 8 gapless words
      expq.push_back(32'h66667777); expq.push_back(32'h44445555);
      expq.push_back(32'h22223333); expq.push_back(32'h00001111);
      expq.push_back(32'hEEEEFFFF); expq.push_back(32'hCCCCDDDD);
      expq.push_back(32'hAAAABBBB); expq.push_back(32'h88889999);
      m_axis_tready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("drain_vld", 128'(m_axis_tvalid), 128'(1));
         take_word();
         @(negedge clk);
      end
      chk("drain_end_vld", 128'(m_axis_tvalid), 128'(0));
      chk("drain_level", 128'(fifo_level), 128'(0));

      // Full: 20 offers, 17 accepted
      m_axis_tready = 1'b0;
      acc = 0;
      for (int i = 0; i < 20; i++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = mk(acc);
         if (s_axis_tready) begin
            push_beat(mk(acc));
            acc++;
         end
         @(negedge clk);
      end
      s_axis_tvalid = 1'b0;
      chk("full_acc", 128'(acc), 128'(17));
      chk("full_tready", 128'(s_axis_tready), 128'(0));
      chk("full_level", 128'(fifo_level), 128'(16));
      m_axis_tready = 1'b1;
      for (int c = 0; c < 200 && expq.size() > 0; c++) begin
         if (m_axis_tvalid) take_word();
         @(negedge clk);
      end
      chk("full_left", 128'(expq.size()), 128'(0));
      chk("full_end_vld", 128'(m_axis_tvalid), 128'(0));

      // Stall: random tready while streaming
      n_in = 0;
      prev_stall = 1'b0;
      prev_data = '0;
      for (int c = 0; c < 600; c++) begin
         if (n_in == 8 && expq.size() == 0) break;
         m_axis_tready = 1'($urandom_range(0, 1));
         if (prev_stall) begin
            chk("stall_vld", 128'(m_axis_tvalid), 128'(1));
            chk("stall_data", 128'(m_axis_tdata), 128'(prev_data));
         end
         if (n_in < 8) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = mk(100 + n_in);
            if (s_axis_tready) begin
               push_beat(mk(100 + n_in));
               n_in++;
            end
         end else begin
            s_axis_tvalid = 1'b0;
         end
         if (m_axis_tvalid && m_axis_tready) take_word();
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_data  = m_axis_tdata;
         @(negedge clk);
      end
      s_axis_tvalid = 1'b0;
      chk("stall_in", 128'(n_in), 128'(8));
      chk("stall_left", 128'(expq.size()), 128'(0));

      // Mid-stream reset after two words
      m_axis_tready = 1'b0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = mk(200);
      @(negedge clk);
      s_axis_tvalid = 1'b0;
      push_beat(mk(200));
      @(negedge clk);
      chk("mr_vld", 128'(m_axis_tvalid), 128'(1));
      m_axis_tready = 1'b1;
      take_word();
      @(negedge clk);
      take_word();
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mr_rst_vld", 128'(m_axis_tvalid), 128'(0));
      chk("mr_rst_level", 128'(fifo_level), 128'(0));
      expq.delete();
      hs_cnt = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("mr_no_partial", 128'(m_axis_tvalid), 128'(0));
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = mk(300);
      @(negedge clk);
      s_axis_tvalid = 1'b0;
      push_beat(mk(300));
      chk("lat_n", 128'(m_axis_tvalid), 128'(0));
      @(negedge clk);
      chk("lat_n1", 128'(m_axis_tvalid), 128'(1));
      for (int i = 0; i < 4; i++) begin
         chk("mr_drain_vld", 128'(m_axis_tvalid), 128'(1));
         take_word();
         @(negedge clk);
      end
      chk("mr_end_vld", 128'(m_axis_tvalid), 128'(0));

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
